ddc_axil_regs: RTL and testbench

DDC_AXIL_REGS -- requirements
Module: ddc_axil_regs

---
 rtl/ddc_axil_pkg.sv | 32 +++
 rtl/ddc_axil_wstrb_merge.sv | 19 +
 rtl/ddc_axil_regs.sv | 182 ++++++++++++++++++
 tb/tb_ddc_axil_regs.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_axil_pkg.sv
// Shared types and constants for the DDC AXI4-Lite register block.
// FSM state encodings, response codes and the register map.
package ddc_axil_pkg;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int NUM_REGS = 4;

    localparam logic [3:0] REG0_OFFSET = 4'h0;
    localparam logic [3:0] REG1_OFFSET = 4'h4;
    localparam logic [3:0] REG2_OFFSET = 4'h8;
    localparam logic [3:0] REG3_OFFSET = 4'hC;

    // Word index within the register window; byte-offset bits are dropped.
    function automatic logic [1:0] reg_index(input logic [3:0] offset);
        return offset[3:2];
    endfunction

endpackage

// File: rtl/ddc_axil_wstrb_merge.sv
// Byte-lane merge: each lane takes the new byte when its strobe is set,
// otherwise keeps the old byte.
module ddc_axil_wstrb_merge #(
    parameter int BYTES = 4
) (
    input  logic [8*BYTES-1:0] old_data,
    input  logic [8*BYTES-1:0] new_data,
    input  logic [BYTES-1:0]   strb,
    output logic [8*BYTES-1:0] merged
);

    always_comb begin
        merged = old_data;
        for (int n = 0; n < BYTES; n++) begin
            if (strb[n]) merged[8*n +: 8] = new_data[8*n +: 8];
        end
    end

endmodule

// File: rtl/ddc_axil_regs.sv
// AXI4-Lite responder with four RW registers feeding the DDC datapath.
// Define DDC_AXIL_ADDR_CHECK_EN to answer SLVERR for byte addresses >= 0x10.
module ddc_axil_regs
    import ddc_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
    output logic [1:0]                      w_state_dbg,
    output logic                            r_state_dbg
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    // Handshakes: a transfer happens on a rising edge where VALID and READY
    // are both 1. READY/VALID outputs are registered; VALID holds until taken.
    logic [DW-1:0]   slv_reg [NUM_REGS];
    w_state_t        w_state;
    r_state_t        r_state;
    logic [AW-1:0]   aw_addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wstrb_q;

    logic            aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data, merged;
    logic [DW/8-1:0] wr_strb;
    logic [1:0]      wr_idx, rd_idx;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // Whichever half arrived earlier comes from its capture register.
    always_comb begin
        wr_addr = (w_state == W_HAVE_ADDR) ? aw_addr_q : S_AXI_AWADDR;
        wr_data = (w_state == W_HAVE_DATA) ? wdata_q   : S_AXI_WDATA;
        wr_strb = (w_state == W_HAVE_DATA) ? wstrb_q   : S_AXI_WSTRB;
        commit  = ((w_state == W_IDLE)      && aw_hs && w_hs) ||
                  ((w_state == W_HAVE_ADDR) && w_hs) ||
                  ((w_state == W_HAVE_DATA) && aw_hs);
    end

    assign wr_idx = reg_index(wr_addr[3:0]);
    assign rd_idx = reg_index(S_AXI_ARADDR[3:0]);

`ifdef DDC_AXIL_ADDR_CHECK_EN
    assign wr_ok = (wr_addr[AW-1:4] == '0);
    assign rd_ok = (S_AXI_ARADDR[AW-1:4] == '0);
`else
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, wr_addr, S_AXI_ARADDR};

    ddc_axil_wstrb_merge #(.BYTES(DW/8)) u_merge (
        .old_data (slv_reg[wr_idx]),
        .new_data (wr_data),
        .strb     (wr_strb),
        .merged   (merged)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) slv_reg[i] <= '0;
        end else if (commit && wr_ok) begin
            slv_reg[wr_idx] <= merged;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state       <= W_IDLE;
            aw_addr_q     <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
        end else begin
            if (commit) begin
                w_state       <= W_RESP;
                S_AXI_AWREADY <= 1'b0;
                S_AXI_WREADY  <= 1'b0;
                S_AXI_BVALID  <= 1'b1;
                S_AXI_BRESP   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                case (w_state)
                    W_IDLE: begin
                        S_AXI_AWREADY <= ~aw_hs;
                        S_AXI_WREADY  <= ~w_hs;
                        if (aw_hs) begin
                            w_state   <= W_HAVE_ADDR;
                            aw_addr_q <= S_AXI_AWADDR;
                        end else if (w_hs) begin
                            w_state <= W_HAVE_DATA;
                            wdata_q <= S_AXI_WDATA;
                            wstrb_q <= S_AXI_WSTRB;
                        end
                    end
                    W_RESP: begin
                        if (S_AXI_BREADY) begin
                            w_state       <= W_IDLE;
                            S_AXI_BVALID  <= 1'b0;
                            S_AXI_AWREADY <= 1'b1;
                            S_AXI_WREADY  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (ar_hs) begin
                        r_state       <= R_DATA;
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RDATA   <= rd_ok ? slv_reg[rd_idx] : '0;
                        S_AXI_RRESP   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_state       <= R_IDLE;
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign slv_reg0    = slv_reg[0];
    assign slv_reg1    = slv_reg[1];
    assign slv_reg2    = slv_reg[2];
    assign slv_reg3    = slv_reg[3];
    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

endmodule

// File: tb/tb_ddc_axil_regs.sv
// Directed bench for ddc_axil_regs; expectations follow DDC_AXIL_ADDR_CHECK_EN.
module tb_ddc_axil_regs;

    logic        ACLK, ARESET;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp, w_state_dbg;
    logic        r_state_dbg;
    logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;

    int n_cmp = 0;
    int n_fail = 0;

    ddc_axil_regs dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .slv_reg0(slv_reg0), .slv_reg1(slv_reg1), .slv_reg2(slv_reg2),
        .slv_reg3(slv_reg3),
        .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        logic aw_go, w_go;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            tick();
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
            n++;
        end
        if (n >= 20) check("aw_w_timeout", 32'(n), 32'd0);
        check("bvalid_next_cycle", 32'(bvalid), 32'd1);
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int n;
        araddr = a;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("ar_timeout", 32'(n), 32'd0);
        tick();
        arvalid = 1'b0;
        check("rvalid_next_cycle", 32'(rvalid), 32'd1);
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    logic [1:0]  resp;
    logic [31:0] rd;

    initial begin
        ARESET = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;

        // reset values
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_resps", {28'd0, bresp, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_regs", slv_reg0 | slv_reg1 | slv_reg2 | slv_reg3, 32'd0);
        check("rst_states", {29'd0, w_state_dbg, r_state_dbg}, 32'd0);
        ARESET = 1'b0;
        #1;
        check("ready_before_edge", {29'd0, awready, wready, arready}, 32'd0);
        tick();
        check("ready_after_edge", {29'd0, awready, wready, arready}, 32'h7);

        // four registers write / read back
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(4 * i), 32'(i + 1), 4'hF, resp);
            check("wr_resp", 32'(resp), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(4 * i), rd, resp);
            check("rd_data", rd, 32'(i + 1));
            check("rd_resp", 32'(resp), 32'd0);
        end
        check("slv_reg0", slv_reg0, 32'h1);
        check("slv_reg1", slv_reg1, 32'h2);
        check("slv_reg2", slv_reg2, 32'h3);
        check("slv_reg3", slv_reg3, 32'h4);

        // AW three cycles ahead of W
        awaddr = 6'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("early_aw_state", 32'(w_state_dbg), 32'd1);
        check("early_aw_readies", {30'd0, awready, wready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("early_aw_no_bvalid", 32'(bvalid), 32'd0);
        end
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("late_w_bvalid", 32'(bvalid), 32'd1);
        check("late_w_reg2", slv_reg2, 32'hDEADBEEF);
        bready = 1'b1; tick(); bready = 1'b0;

        // byte strobes
        axi_write(6'h04, 32'hAABBCCDD, 4'b0010, resp);
        check("strb_reg1", slv_reg1, 32'h0000CC02);
        axi_write(6'h04, 32'hFFFFFFFF, 4'b0000, resp);
        check("strb0_reg1", slv_reg1, 32'h0000CC02);
        check("strb0_resp", 32'(resp), 32'd0);

        // write response held off by BREADY
        awaddr = 6'h04; wdata = 32'h11112222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bhold_bvalid", 32'(bvalid), 32'd1);
            check("bhold_readies", {30'd0, awready, wready}, 32'd0);
            check("bhold_bresp", 32'(bresp), 32'd0);
            tick();
        end
        bready = 1'b1; tick(); bready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("bhold_single_resp", 32'(bvalid), 32'd0);
            tick();
        end
        check("bhold_reg1", slv_reg1, 32'h11112222);

        // read data held off by RREADY
        araddr = 6'h04; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rhold_rvalid", 32'(rvalid), 32'd1);
            check("rhold_rdata", rdata, 32'h11112222);
            check("rhold_arready", 32'(arready), 32'd0);
            tick();
        end
        rready = 1'b1; tick(); rready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rhold_single_resp", 32'(rvalid), 32'd0);
            tick();
        end

        // read and write commit to the same register in one cycle
        awaddr = 6'h0C; wdata = 32'h00000099; wstrb = 4'hF; araddr = 6'h0C;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_cycle_rdata", rdata, 32'h4);
        check("same_cycle_reg3", slv_reg3, 32'h99);
        check("same_cycle_valids", {30'd0, bvalid, rvalid}, 32'h3);
        bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;

        // W ahead of AW
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("early_w_state", 32'(w_state_dbg), 32'd2);
        check("early_w_readies", {30'd0, awready, wready}, 32'h2);
        awaddr = 6'h00; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("late_aw_bvalid", 32'(bvalid), 32'd1);
        check("late_aw_reg0", slv_reg0, 32'hA5A5A5A5);
        bready = 1'b1; tick(); bready = 1'b0;

        // out-of-window address
        axi_write(6'h20, 32'h55, 4'hF, resp);
        axi_read(6'h20, rd, resp);
`ifdef DDC_AXIL_ADDR_CHECK_EN
        check("oob_reg0", slv_reg0, 32'hA5A5A5A5);
        check("oob_rdata", rd, 32'h0);
        check("oob_rresp", 32'(resp), 32'h2);
`else
        check("alias_reg0", slv_reg0, 32'h55);
        check("alias_rdata", rd, 32'h55);
        check("alias_rresp", 32'(resp), 32'h0);
`endif

        // reset while holding an address
        awaddr = 6'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("pre_rst_state", 32'(w_state_dbg), 32'd1);
        ARESET = 1'b1;
        #1;
        check("mid_rst_readies", {29'd0, awready, wready, arready}, 32'd0);
        check("mid_rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
        check("mid_rst_regs", slv_reg0 | slv_reg1 | slv_reg2 | slv_reg3, 32'd0);
        check("mid_rst_state", 32'(w_state_dbg), 32'd0);
        tick();
        ARESET = 1'b0;
        tick();
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("post_rst_w_state", 32'(w_state_dbg), 32'd2);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_no_bvalid", 32'(bvalid), 32'd0);
            check("post_rst_reg1", slv_reg1, 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
